// File: rtl/prog_pattern_detector.sv
// Serial pattern detector with programmable pattern, care mask and overlap mode.
// Define PD_MATCH_COUNTER_EN to include the saturating match counter.
module prog_pattern_detector #(
  parameter int                   PAT_WIDTH = 4,
  parameter int                   CNT_WIDTH = 8,
  parameter logic [PAT_WIDTH-1:0] PAT_RESET = PAT_WIDTH'(4'b1011)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 d_i,
  input  logic                 valid_i,
  input  logic                 cfg_load_i,
  input  logic [PAT_WIDTH-1:0] pattern_i,
  input  logic [PAT_WIDTH-1:0] mask_i,
  input  logic                 overlap_i,
  input  logic                 clr_cnt_i,
  output logic                 pattern_detected_o,
  output logic [CNT_WIDTH-1:0] match_count_o,
  output logic                 cnt_sat_o
);

  localparam int                FILL_W    = $clog2(PAT_WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_WIDTH);

  logic [PAT_WIDTH-1:0] r_hist;
  logic [FILL_W-1:0]    r_fill;
  logic [PAT_WIDTH-1:0] r_pattern;
  logic [PAT_WIDTH-1:0] r_mask;
  logic                 r_overlap;
  logic                 r_det;

  logic [PAT_WIDTH-1:0] w_new_hist;
  logic [FILL_W-1:0]    w_fill_next;
  logic                 w_sample;
  logic                 w_match;

  always_comb begin
    w_sample    = valid_i && !cfg_load_i;
    w_new_hist  = {r_hist[PAT_WIDTH-2:0], d_i};
    w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
    // The fill count includes the bit being sampled on this edge.
    w_match     = w_sample && (w_fill_next == FILL_FULL) &&
                  (((w_new_hist ^ r_pattern) & r_mask) == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= PAT_RESET;
      r_mask    <= '1;
      r_overlap <= 1'b1;
      r_det     <= 1'b0;
    end else begin
      r_det <= w_match;
      if (cfg_load_i) begin
        r_pattern <= pattern_i;
        r_mask    <= mask_i;
        r_overlap <= overlap_i;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (valid_i) begin
        r_hist <= w_new_hist;
        r_fill <= (w_match && !r_overlap) ? '0 : w_fill_next;
      end
    end
  end

  assign pattern_detected_o = r_det;

`ifdef PD_MATCH_COUNTER_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_count;

  // Clear has priority over a coincident match; loading a new pattern keeps the count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (clr_cnt_i) begin
      r_count <= '0;
    end else if (w_match && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign match_count_o = r_count;
  assign cnt_sat_o     = (r_count == CNT_MAX);
`else
  logic w_unused_clr;

  assign w_unused_clr  = clr_cnt_i;
  assign match_count_o = '0;
  assign cnt_sat_o     = 1'b0;
`endif

endmodule

// File: tb/tb_prog_pattern_detector.sv
// Self-checking bench for prog_pattern_detector against a queue-based reference model.
// Counter expectations follow PD_MATCH_COUNTER_EN the same way the design does.
module tb_prog_pattern_detector;

  localparam int PW   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PD_MATCH_COUNTER_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          d_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          cfg_load_i = 1'b0;
  logic [PW-1:0] pattern_i = '0;
  logic [PW-1:0] mask_i = '0;
  logic          overlap_i = 1'b0;
  logic          clr_cnt_i = 1'b0;
  logic          pattern_detected_o;
  logic [CW-1:0] match_count_o;
  logic          cnt_sat_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits sampled since the last restart, newest at the back.
  bit            q[$];
  logic [PW-1:0] m_pat;
  logic [PW-1:0] m_mask;
  bit            m_ov;
  bit            exp_det;
  int            exp_cnt;

  prog_pattern_detector #(.PAT_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .d_i               (d_i),
    .valid_i           (valid_i),
    .cfg_load_i        (cfg_load_i),
    .pattern_i         (pattern_i),
    .mask_i            (mask_i),
    .overlap_i         (overlap_i),
    .clr_cnt_i         (clr_cnt_i),
    .pattern_detected_o(pattern_detected_o),
    .match_count_o     (match_count_o),
    .cnt_sat_o         (cnt_sat_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_count_out();
    return HAS_CNT ? exp_cnt : 0;
  endfunction

  function automatic bit exp_sat_out();
    return HAS_CNT && (exp_cnt == CMAX);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat   = 4'b1011;
    m_mask  = '1;
    m_ov    = 1'b1;
    exp_det = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic model_edge();
    bit            hit;
    logic [PW-1:0] win;
    hit = 1'b0;
    if (cfg_load_i) begin
      m_pat  = pattern_i;
      m_mask = mask_i;
      m_ov   = overlap_i;
      q.delete();
    end else if (valid_i) begin
      q.push_back(d_i);
      if (q.size() > PW) void'(q.pop_front());
      if (q.size() == PW) begin
        for (int i = 0; i < PW; i++) win[PW-1-i] = q[i];
        hit = (((win ^ m_pat) & m_mask) == '0);
      end
      if (hit && !m_ov) q.delete();
    end
    exp_det = hit;
    if (clr_cnt_i) exp_cnt = 0;
    else if (hit && exp_cnt < CMAX) exp_cnt++;
  endtask

  // One clock: apply inputs, advance the model at the edge, settle 1 time unit.
  task automatic drive(input logic d, input logic v, input logic ld, input logic clr,
                       input logic [PW-1:0] pat, input logic [PW-1:0] msk, input logic ov);
    d_i = d; valid_i = v; cfg_load_i = ld; clr_cnt_i = clr;
    pattern_i = pat; mask_i = msk; overlap_i = ov;
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic bit_in(input logic d);
    drive(d, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic load(input logic [PW-1:0] pat, input logic [PW-1:0] msk, input logic ov);
    drive(1'b1, 1'b1, 1'b1, 1'b0, pat, msk, ov);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (pattern_detected_o !== 1'b0 || match_count_o !== '0 || cnt_sat_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: det=%0b cnt=%0d sat=%0b, required 0/0/0",
               pattern_detected_o, match_count_o, cnt_sat_o);
    end
    rst_i = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    logic [6:0] stream, want;
    stream = 7'b1011011;
    want   = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      bit_in(stream[6-i]);
      n_checks++;
      if (pattern_detected_o !== want[6-i] || exp_det !== want[6-i]) begin
        n_fail++;
        $display("FAIL basic_det bit %0d: got %0b model %0b, required %0b",
                 i + 1, pattern_detected_o, exp_det, want[6-i]);
      end
    end
    n_checks++;
    if (match_count_o !== CW'(HAS_CNT ? 2 : 0)) begin
      n_fail++;
      $display("FAIL basic_count: got %0d, required %0d", match_count_o, HAS_CNT ? 2 : 0);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] want_no, want_ov;
    int         pulses;
    want_no = 8'b00010001;
    want_ov = 8'b00011111;
    load(4'b1111, 4'b1111, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bit_in(1'b1);
      n_checks++;
      if (pattern_detected_o !== want_no[7-i]) begin
        n_fail++;
        $display("FAIL nonoverlap_det bit %0d: got %0b, required %0b",
                 i + 1, pattern_detected_o, want_no[7-i]);
      end
    end
    load(4'b1111, 4'b1111, 1'b1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      bit_in(1'b1);
      pulses += int'(pattern_detected_o);
      n_checks++;
      if (pattern_detected_o !== want_ov[7-i]) begin
        n_fail++;
        $display("FAIL overlap_det bit %0d: got %0b, required %0b",
                 i + 1, pattern_detected_o, want_ov[7-i]);
      end
    end
    n_checks++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL overlap_pulses: got %0d, required 5", pulses);
    end
  endtask

  task automatic test_mask();
    logic [3:0] stream;
    stream = 4'b1011;
    load(4'b0010, 4'b0110, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bit_in(stream[3-i]);
      n_checks++;
      if (pattern_detected_o !== (i == 3)) begin
        n_fail++;
        $display("FAIL mask_det bit %0d: got %0b, required %0b", i + 1, pattern_detected_o, i == 3);
      end
    end
  endtask

  task automatic test_valid_gap();
    logic [6:0] dv, vv;
    dv = {2'b10, 3'($urandom_range(7)), 2'b11};
    vv = 7'b1100011;
    load(4'b1011, 4'b1111, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(dv[6-i], vv[6-i], 1'b0, 1'b0, '0, '0, 1'b0);
      n_checks++;
      if (pattern_detected_o !== (i == 6)) begin
        n_fail++;
        $display("FAIL gap_det cycle %0d: got %0b, required %0b", i, pattern_detected_o, i == 6);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] pre;
    logic [6:0] post;
    pre = 4'b1011;
    for (int i = 0; i < 4; i++) bit_in(pre[3-i]);
    n_checks++;
    if (pattern_detected_o !== 1'b1) begin
      n_fail++;
      $display("FAIL resetmid_prepulse: got %0b, required 1", pattern_detected_o);
    end
    rst_i = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (pattern_detected_o !== 1'b0 || match_count_o !== '0 || cnt_sat_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: det=%0b cnt=%0d sat=%0b, required 0/0/0",
               pattern_detected_o, match_count_o, cnt_sat_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) bit_in(pre[3-i]);
    rst_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    post = 7'b1_0_1_1_011;
    for (int i = 0; i < 4; i++) begin
      bit_in(post[6-i]);
      n_checks++;
      if (pattern_detected_o !== (i == 3) || exp_det !== (i == 3)) begin
        n_fail++;
        $display("FAIL resetmid_det bit %0d: got %0b model %0b, required %0b",
                 i + 1, pattern_detected_o, exp_det, i == 3);
      end
    end
  endtask

  task automatic test_counter_sat();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    load(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 270; i++) begin
      bit_in(1'($urandom));
      n_checks++;
      if (pattern_detected_o !== exp_det) begin
        n_fail++;
        $display("FAIL sat_det bit %0d: got %0b, required %0b", i + 1, pattern_detected_o, exp_det);
      end
    end
    n_checks++;
    if (match_count_o !== CW'(HAS_CNT ? CMAX : 0) || cnt_sat_o !== HAS_CNT) begin
      n_fail++;
      $display("FAIL sat_count: cnt=%0d sat=%0b, required %0d/%0b",
               match_count_o, cnt_sat_o, HAS_CNT ? CMAX : 0, HAS_CNT);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    n_checks++;
    if (pattern_detected_o !== 1'b1 || match_count_o !== '0 || cnt_sat_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_with_match: det=%0b cnt=%0d sat=%0b, required 1/0/0",
               pattern_detected_o, match_count_o, cnt_sat_o);
    end
    bit_in(1'b0);
    n_checks++;
    if (match_count_o !== CW'(HAS_CNT ? 1 : 0)) begin
      n_fail++;
      $display("FAIL count_after_clr: got %0d, required %0d", match_count_o, HAS_CNT ? 1 : 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom), ($urandom_range(99) < 80), ($urandom_range(99) < 3),
            ($urandom_range(99) < 2), PW'($urandom), PW'($urandom), 1'($urandom));
      n_checks++;
      if (pattern_detected_o !== exp_det || match_count_o !== CW'(exp_count_out()) ||
          cnt_sat_o !== exp_sat_out()) begin
        n_fail++;
        $display("FAIL rand cycle %0d: det=%0b cnt=%0d sat=%0b, required %0b/%0d/%0b",
                 i, pattern_detected_o, match_count_o, cnt_sat_o,
                 exp_det, exp_count_out(), exp_sat_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_mask();
    test_valid_gap();
    test_reset_mid();
    test_counter_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_pattern_detector.md
PROG_PATTERN_DETECTOR -- requirements
Module: prog_pattern_detector

Interface
REQ-001 SHALL have parameter PAT_WIDTH, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, match counter width, legal range 1..16.
REQ-003 SHALL have parameter PAT_RESET, default 4'b1011 (PAT_WIDTH bits), pattern value held after reset.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port d_i  input  1  serial data bit.
REQ-007 SHALL have port valid_i  input  1  d_i is sampled only when high.
REQ-008 SHALL have port cfg_load_i  input  1  load pattern, mask and mode.
REQ-009 SHALL have port pattern_i  input  PAT_WIDTH  pattern; bit PAT_WIDTH-1 is the first bit received.
REQ-010 SHALL have port mask_i  input  PAT_WIDTH  care mask; 1 = compare, 0 = don't care.
REQ-011 SHALL have port overlap_i  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 SHALL have port clr_cnt_i  input  1  synchronous clear of match counter.
REQ-013 SHALL have port pattern_detected_o  output  1  one-cycle match pulse.
REQ-014 SHALL have port match_count_o  output  CNT_WIDTH  number of matches.
REQ-015 SHALL have port cnt_sat_o  output  1  counter saturated.

Function
REQ-016 On a rising edge with valid_i=1 and cfg_load_i=0, history SHALL shift {hist[PAT_WIDTH-2:0], d_i}; with valid_i=0, history and fill SHALL hold.
REQ-017 A fill counter SHALL count sampled bits since reset, load or non-overlapping match, saturating at PAT_WIDTH.
REQ-018 A match SHALL occur on an edge sampling a bit when fill (including that bit) equals PAT_WIDTH and ((new_hist ^ pattern_reg) & mask_reg) == 0.
REQ-019 pattern_detected_o SHALL be registered: high for exactly the one cycle following the matching edge; consecutive matching edges give consecutive high cycles; latency = 1 clock from sampling the final bit.
REQ-020 Overlap mode SHALL keep history and fill after a match; non-overlap mode SHALL reset fill to 0 on a match, so the next match needs PAT_WIDTH new bits.
REQ-021 cfg_load_i=1 SHALL register pattern_i, mask_i and overlap_i, clear history and fill, and discard d_i that cycle (load wins over valid_i); no match SHALL be reported on a load edge.
REQ-022 mask_reg all zero SHALL match on every sampled bit once fill reaches PAT_WIDTH.
REQ-023 Match counter SHALL increment by 1 per match and saturate at 2^CNT_WIDTH-1; cnt_sat_o SHALL be high while count equals max.
REQ-024 clr_cnt_i=1 SHALL set count to 0 and cnt_sat_o to 0 regardless of a simultaneous match; cfg_load_i SHALL NOT clear the counter.

Reset
REQ-025 rst_i low SHALL immediately clear history, fill, pattern_detected_o, match_count_o, cnt_sat_o to 0, and set pattern_reg=PAT_RESET, mask_reg=all ones, overlap=1.
REQ-026 Reset asserted mid-sequence SHALL discard partial history; detection SHALL restart from fill=0 on the first valid edge after release.

Configuration
REQ-027 Macro PD_MATCH_COUNTER_EN defined SHALL include the match counter per REQ-023/024.
REQ-028 Macro PD_MATCH_COUNTER_EN undefined SHALL remove counter logic, tie match_count_o and cnt_sat_o to 0, and ignore clr_cnt_i; detection behaviour SHALL be unchanged.

Verification
REQ-029 Defaults, valid_i=1, stream 1,0,1,1,0,1,1 -> pattern_detected_o high after bits 4 and 7; match_count_o=2.
REQ-030 Load pattern 1111, mask 1111, overlap 0; stream of 8 ones -> pulses after bits 4 and 8 only; overlap 1 same stream -> pulses after bits 4..8 (5 pulses).
REQ-031 Load pattern 0010, mask 0110; stream 1,0,1,1 -> pulse after bit 4 (don't-care bits ignored).
REQ-032 Stream 1,0,1,1 with valid_i=0 for 3 cycles between bits 2 and 3 -> single pulse after bit 4; no pulse during gap.
REQ-033 CNT_WIDTH=2, 5 matches -> match_count_o=3, cnt_sat_o=1; clr_cnt_i pulse coincident with 6th match -> count 0, cnt_sat_o 0.
REQ-034 Stream 1,0,1 then rst_i low 1 cycle then bit 1 -> no pulse; then 0,1,1 -> no pulse until fill reaches 4 and 1011 is seen.
